p405s_icu_regicu_arb: RTL and testbench

//   Arbiter/sequencer for the shared 32-bit ICU holding register (P1EUL2 latch, E1 load enable).

---
 rtl/p405s_icu_regicu_arb_if.sv | 28 ++
 rtl/p405s_icu_regicu_arb.sv | 130 +++++++++++++
 tb/tb_p405s_icu_regicu_arb.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/p405s_icu_regicu_arb_if.sv
// Request/holding-register bus between the ICU requesters, the arbiter and the consumer.
interface p405s_icu_regicu_arb_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 32
);
    logic [0:NREQ-1]    reqV;
    logic [0:NREQ*DW-1] reqData;
    logic [0:NREQ-1]    reqGnt;
    logic               regE1;
    logic [0:DW-1]      regD;
    logic               regVal;
    logic [0:2]         regOwner;
    logic               consAck;
    logic               flush;
    logic               tmoErr;

    // Arbiter side
    modport master (
        input  reqV, reqData, consAck, flush,
        output reqGnt, regE1, regD, regVal, regOwner, tmoErr
    );

    // Requester/consumer side
    modport slave (
        output reqV, reqData, consAck, flush,
        input  reqGnt, regE1, regD, regVal, regOwner, tmoErr
    );
endinterface

// File: rtl/p405s_icu_regicu_arb.sv
// Round-robin arbiter/sequencer for the shared ICU holding register (P1EUL2 latch).
// Grants are combinational (Mealy) in the load cycle; ownership is held until
// consumer ack, watchdog timeout or flush.
module p405s_icu_regicu_arb #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 32,
    parameter int unsigned TMO  = 15
) (
    input  logic                        CB,
    input  logic                        resetN,
    p405s_icu_regicu_arb_if.master      bus
);
    localparam int unsigned OW = 3;
    localparam int unsigned WW = (TMO == 0) ? 1 : $clog2(TMO + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, state_d;
    logic [OW-1:0]   owner, owner_d;
    logic [OW-1:0]   rr_ptr, rr_d;
    logic [WW-1:0]   wdog, wdog_d;
    logic            tmo_q, tmo_d;

    logic [OW-1:0]   next_rr;
    logic [OW-1:0]   scan;
    logic [OW-1:0]   win;
    logic            found;
    logic            load;
    logic [0:NREQ-1] gnt_c;
    logic [0:DW-1]   d_c;

    // State, ownership, pointer and watchdog registers
    always_ff @(posedge CB or negedge resetN) begin
        if (!resetN) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            wdog   <= '0;
            tmo_q  <= 1'b0;
        end else begin
            state  <= state_d;
            owner  <= owner_d;
            rr_ptr <= rr_d;
            wdog   <= wdog_d;
            tmo_q  <= tmo_d;
        end
    end

    // Arbitration, load decision, next state and load-cycle outputs
    always_comb begin
        state_d = state;
        owner_d = owner;
        rr_d    = rr_ptr;
        wdog_d  = wdog;
        tmo_d   = 1'b0;
        found   = 1'b0;
        win     = '0;
        gnt_c   = '0;
        d_c     = '0;

        next_rr = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
        // A back-to-back release advances the pointer in the same cycle, so scan from there
        scan = (state == HOLD && bus.consAck && !bus.flush) ? next_rr : rr_ptr;

        for (int k = 0; k < int'(NREQ); k++) begin
            if (!found && bus.reqV[k] && (OW'(k) >= scan)) begin
                found = 1'b1;
                win   = OW'(k);
            end
        end
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!found && bus.reqV[k]) begin
                found = 1'b1;
                win   = OW'(k);
            end
        end

        load = resetN && !bus.flush && found &&
               ((state == IDLE) || (state == HOLD && bus.consAck));

        for (int k = 0; k < int'(NREQ); k++) begin
            if (load && win == OW'(k)) begin
                gnt_c[k] = 1'b1;
                d_c      = bus.reqData[k*DW +: DW];
            end
        end

        if (bus.flush) begin
            state_d = IDLE;
            wdog_d  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state_d = HOLD;
                        owner_d = win;
                        wdog_d  = '0;
                    end
                end
                HOLD: begin
                    if (bus.consAck) begin
                        rr_d   = next_rr;
                        wdog_d = '0;
                        if (load) begin
                            owner_d = win;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if ((TMO != 0) && (wdog == WW'(TMO - 1))) begin
                        state_d = IDLE;
                        tmo_d   = 1'b1;
                        rr_d    = next_rr;
                        wdog_d  = '0;
                    end else if (wdog != {WW{1'b1}}) begin
                        wdog_d = wdog + WW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.reqGnt   = gnt_c;
    assign bus.regE1    = load;
    assign bus.regD     = d_c;
    assign bus.regVal   = (state == HOLD);
    assign bus.regOwner = owner;
    assign bus.tmoErr   = tmo_q;

endmodule

// File: tb/tb_p405s_icu_regicu_arb.sv
// Directed bench for the ICU holding-register arbiter.
module tb_p405s_icu_regicu_arb;
    localparam int unsigned NREQ = 3;
    localparam int unsigned DW   = 32;

    logic CB = 1'b0;
    logic resetN;
    int   errs   = 0;
    int   checks = 0;
    logic [31:0] dat [3] = '{32'hDEADBEEF, 32'h1111_2222, 32'h3333_4444};

    always #5 CB = ~CB;

    p405s_icu_regicu_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

    p405s_icu_regicu_arb #(.NREQ(NREQ), .DW(DW), .TMO(15)) dut (
        .CB     (CB),
        .resetN (resetN),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CB);
        #1;
    endtask

    task automatic do_reset();
        resetN      = 1'b0;
        bus.reqV    = '0;
        bus.consAck = 1'b0;
        bus.flush   = 1'b0;
        step();
        resetN = 1'b1;
    endtask

    initial begin
        bus.reqData = {dat[0], dat[1], dat[2]};
        bus.reqV    = 3'b111;
        bus.consAck = 1'b0;
        bus.flush   = 1'b0;
        resetN      = 1'b0;

        // Reset holds grants and load enable low even with all requests up
        #2;
        check("rst_gnt", 32'(bus.reqGnt), 32'h0);
        check("rst_e1", 32'(bus.regE1), 32'h0);
        check("rst_val", 32'(bus.regVal), 32'h0);
        step();
        check("rst_gnt_edge", 32'(bus.reqGnt), 32'h0);
        check("rst_owner", 32'(bus.regOwner), 32'h0);
        resetN   = 1'b1;
        bus.reqV = '0;
        step();
        check("idle_val", 32'(bus.regVal), 32'h0);
        check("idle_e1", 32'(bus.regE1), 32'h0);

        // Single load from requester 0
        bus.reqV = 3'b100;
        @(negedge CB);
        check("ld_gnt", 32'(bus.reqGnt), 32'h4);
        check("ld_e1", 32'(bus.regE1), 32'h1);
        check("ld_d", 32'(bus.regD), 32'hDEADBEEF);
        step();
        bus.reqV = '0;
        check("ld_val", 32'(bus.regVal), 32'h1);
        check("ld_owner", 32'(bus.regOwner), 32'h0);
        @(negedge CB);
        check("hold_nogrant", 32'(bus.reqGnt), 32'h0);
        check("hold_d0", 32'(bus.regD), 32'h0);
        step();

        // Round-robin back-to-back loads with ack every HOLD cycle
        do_reset();
        bus.reqV    = 3'b111;
        bus.consAck = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CB);
            check($sformatf("rr_gnt%0d", i), 32'(bus.reqGnt), 32'(3'b100 >> (i % 3)));
            check($sformatf("rr_d%0d", i), 32'(bus.regD), dat[i % 3]);
            step();
            check($sformatf("rr_val%0d", i), 32'(bus.regVal), 32'h1);
            check($sformatf("rr_own%0d", i), 32'(bus.regOwner), 32'(i % 3));
        end
        bus.reqV = '0;
        step();
        check("rr_release", 32'(bus.regVal), 32'h0);

        // Watchdog: load req1, never ack
        do_reset();
        bus.reqV = 3'b010;
        @(negedge CB);
        check("tmo_gnt", 32'(bus.reqGnt), 32'h2);
        step();
        bus.reqV = '0;
        check("tmo_t0", 32'(bus.tmoErr), 32'h0);
        for (int c = 1; c <= 15; c++) begin
            step();
            check($sformatf("tmo_c%0d", c), 32'(bus.tmoErr), (c == 15) ? 32'h1 : 32'h0);
        end
        check("tmo_val", 32'(bus.regVal), 32'h0);
        bus.reqV = 3'b111;
        @(negedge CB);
        check("tmo_next", 32'(bus.reqGnt), 32'h1);
        step();
        bus.reqV = '0;
        check("tmo_pulse", 32'(bus.tmoErr), 32'h0);
        check("tmo_owner", 32'(bus.regOwner), 32'h2);

        // Flush beats ack; pointer stays put
        do_reset();
        bus.reqV = 3'b010;
        step();
        check("fl_owner", 32'(bus.regOwner), 32'h1);
        bus.reqV    = 3'b011;
        bus.flush   = 1'b1;
        bus.consAck = 1'b1;
        @(negedge CB);
        check("fl_gnt", 32'(bus.reqGnt), 32'h0);
        check("fl_e1", 32'(bus.regE1), 32'h0);
        step();
        bus.flush   = 1'b0;
        bus.consAck = 1'b0;
        check("fl_idle", 32'(bus.regVal), 32'h0);
        @(negedge CB);
        check("fl_regrant", 32'(bus.reqGnt), 32'h2);
        step();
        bus.reqV = '0;
        check("fl_val", 32'(bus.regVal), 32'h1);

        // Asynchronous reset between edges while holding
        do_reset();
        bus.reqV = 3'b001;
        step();
        check("ar_owner", 32'(bus.regOwner), 32'h2);
        bus.reqV = 3'b111;
        @(negedge CB);
        #1;
        resetN = 1'b0;
        #1;
        check("ar_val", 32'(bus.regVal), 32'h0);
        check("ar_owner0", 32'(bus.regOwner), 32'h0);
        check("ar_gnt", 32'(bus.reqGnt), 32'h0);
        step();
        check("ar_gnt_edge", 32'(bus.reqGnt), 32'h0);
        check("ar_e1", 32'(bus.regE1), 32'h0);
        resetN = 1'b1;
        @(negedge CB);
        check("ar_after", 32'(bus.reqGnt), 32'h4);
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
